// File: rtl/rv_pkg.sv
// rv_pkg: shared opcode constants and sequencer state encoding for the decode-stage controller.
package rv_pkg;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] MAC   = 7'b1111111;

    typedef enum logic [1:0] {RUN, MAC_WAIT, REDIRECT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);
    end
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: decode-stage stall/flush sequencing for load-use hazards, EX redirects and the multi-cycle MAC.
module hazard_sequencer
    import rv_pkg::*;
#(
    parameter int MAC_CYCLES   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             flush,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             mac_start,
    output logic             mac_abort,
    output logic             mac_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [3:0] MAC_LOAD = 4'(MAC_CYCLES - 2);
    localparam logic [3:0] FL_LOAD  = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam state_t     FL_NEXT  = FLUSH_CYCLES > 1 ? REDIRECT : RUN;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       uses_rs1, uses_rs2, lu, flush_inc;

    assign uses_rs1 = !(id_opcode inside {LUI, AUIPC, JAL});
    assign uses_rs2 = id_opcode inside {BCC, SCC, RCC, MAC};
    assign lu = id_valid && ex_mem_read && ex_rd != 5'd0 &&
                ((ex_rd == id_rs1 && uses_rs1) || (ex_rd == id_rs2 && uses_rs2));

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        stall         = 1'b0;
        flush         = 1'b0;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        mac_start     = 1'b0;
        mac_abort     = 1'b0;
        mac_busy      = 1'b0;
        flush_inc     = 1'b0;
        case (state)
            RUN: begin
                if (ex_redirect) begin
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = FL_NEXT;
                    cnt_d     = FL_LOAD;
                end else if (lu) begin
                    stall = 1'b1;
                end else if (id_valid && id_opcode == MAC) begin
                    mac_start = 1'b1;
                    stall     = 1'b1;
                    state_d   = MAC_WAIT;
                    cnt_d     = MAC_LOAD;
                end
            end
            MAC_WAIT: begin
                mac_busy = 1'b1;
                if (ex_redirect) begin
                    mac_abort = 1'b1;
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = FL_NEXT;
                    cnt_d     = FL_LOAD;
                end else begin
                    stall   = 1'b1;
                    state_d = cnt == 4'd0 ? RUN : MAC_WAIT;
                    cnt_d   = cnt == 4'd0 ? cnt : cnt - 4'd1;
                end
            end
            REDIRECT: begin
                flush   = 1'b1;
                state_d = cnt == 4'd0 ? RUN : REDIRECT;
                cnt_d   = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: state_d = RUN;
        endcase
        pc_write_en   = pc_write_en && !stall;
        ifid_write_en = ifid_write_en && !stall;
        // Reset forces the idle control word at once, so an in-flight MAC drops without an abort pulse.
        if (!reset) begin
            stall         = 1'b0;
            flush         = 1'b0;
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            mac_start     = 1'b0;
            mac_abort     = 1'b0;
            mac_busy      = 1'b0;
            flush_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst_n(reset),
        .inc  (stall),
        .clr  (cnt_clr),
        .q    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rst_n(reset),
        .inc  (flush_inc),
        .clr  (cnt_clr),
        .q    (flush_cnt)
    );
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed and random stimulus checked against a cycle-budget model of the sequencer rules.
module tb_hazard_sequencer;
    localparam int M = 4;
    localparam int F = 2;
    localparam int SW = 4;

    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_valid = 0, ex_mem_read = 0, ex_redirect = 0, cnt_clr = 0;
    logic stall, flush, pc_write_en, ifid_write_en, mac_start, mac_abort, mac_busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_stall, s_flush, s_pc, s_ifid, s_start, s_abort, s_busy;
    logic [SW-1:0] s_stall_cnt, s_flush_cnt;

    int tests = 0, fails = 0;
    int mac_left = 0, fl_left = 0, sc = 0, fc = 0;
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f};

    always #5 clk = ~clk;

    hazard_sequencer #(.MAC_CYCLES(M), .FLUSH_CYCLES(F), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_valid(id_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .mac_start(mac_start), .mac_abort(mac_abort),
        .mac_busy(mac_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_sequencer #(.MAC_CYCLES(M), .FLUSH_CYCLES(F), .CNT_W(SW)) sat (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_valid(id_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .cnt_clr(cnt_clr), .stall(s_stall), .flush(s_flush), .pc_write_en(s_pc),
        .ifid_write_en(s_ifid), .mac_start(s_start), .mac_abort(s_abort),
        .mac_busy(s_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int w);
        return v > (1 << w) - 1 ? (1 << w) - 1 : v;
    endfunction

    function automatic bit hazard(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic v, input logic mr, input logic [4:0] rd);
        bit need1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        bit need2 = op == 7'h63 || op == 7'h23 || op == 7'h33 || op == 7'h7f;
        return v && mr && rd != 0 && ((rd == r1 && need1) || (rd == r2 && need2));
    endfunction

    task automatic chk_counts();
        chk("stall_cnt", 32'(stall_cnt), clamp(sc, 16));
        chk("flush_cnt", 32'(flush_cnt), clamp(fc, 16));
        chk("sat_stall_cnt", 32'(s_stall_cnt), clamp(sc, SW));
        chk("sat_flush_cnt", 32'(s_flush_cnt), clamp(fc, SW));
    endtask

    task automatic model_reset();
        mac_left = 0; fl_left = 0; sc = 0; fc = 0;
    endtask

    // Drive one cycle of inputs, check the Mealy outputs mid-cycle, then the counters after the edge.
    task automatic cyc(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic v,
                       input logic mr, input logic [4:0] rd, input logic rdr, input logic clr);
        bit e_st = 0, e_fl = 0, e_start = 0, e_abort = 0, e_busy = 0, finc = 0;
        id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_valid = v;
        ex_mem_read = mr; ex_rd = rd; ex_redirect = rdr; cnt_clr = clr;
        @(negedge clk);
        if (fl_left > 0) begin
            e_fl = 1; fl_left--;
        end else if (mac_left > 0) begin
            e_busy = 1;
            if (rdr) begin
                e_abort = 1; e_fl = 1; finc = 1; mac_left = 0; fl_left = F - 1;
            end else begin
                e_st = 1; mac_left--;
            end
        end else if (rdr) begin
            e_fl = 1; finc = 1; fl_left = F - 1;
        end else if (hazard(op, r1, r2, v, mr, rd)) begin
            e_st = 1;
        end else if (v && op == 7'h7f) begin
            e_start = 1; e_st = 1; mac_left = M - 1;
        end
        chk("stall", 32'(stall), 32'(e_st));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("pc_write_en", 32'(pc_write_en), 32'(!e_st));
        chk("ifid_write_en", 32'(ifid_write_en), 32'(!e_st));
        chk("mac_start", 32'(mac_start), 32'(e_start));
        chk("mac_abort", 32'(mac_abort), 32'(e_abort));
        chk("mac_busy", 32'(mac_busy), 32'(e_busy));
        chk("sat_stall", 32'(s_stall), 32'(e_st));
        if (clr) begin
            sc = 0; fc = 0;
        end else begin
            sc += int'(e_st); fc += int'(finc);
        end
        @(posedge clk);
        #1;
        chk_counts();
    endtask

    task automatic idle();
        cyc(7'h13, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_pc", 32'(pc_write_en), 1);
        chk("rst_ifid", 32'(ifid_write_en), 1);
        chk("rst_busy", 32'(mac_busy), 0);
        chk_counts();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        idle();
        // load-use on rs1, then the bubble cycle; ex_rd=0 never stalls
        cyc(7'h33, 5, 6, 1, 1, 5, 0, 0);
        cyc(7'h33, 5, 6, 1, 0, 0, 0, 0);
        cyc(7'h33, 0, 6, 1, 1, 0, 0, 0);
        // rs2 filtering: addi uses rs1 only, lui uses neither
        cyc(7'h13, 6, 6, 1, 1, 6, 0, 0);
        cyc(7'h13, 1, 6, 1, 1, 6, 0, 0);
        cyc(7'h37, 6, 6, 1, 1, 6, 0, 0);
        cyc(7'h33, 1, 6, 1, 1, 6, 0, 0);
        // MAC held in ID for its full latency, then leaves
        repeat (M) cyc(7'h7f, 1, 2, 1, 0, 0, 0, 0);
        idle();
        // redirect beats load-use; second redirect during the flush window is ignored
        cyc(7'h33, 5, 6, 1, 1, 5, 1, 0);
        cyc(7'h33, 5, 6, 1, 1, 5, 1, 0);
        idle();
        // redirect two cycles into a MAC aborts it
        cyc(7'h7f, 1, 2, 1, 0, 0, 0, 0);
        cyc(7'h7f, 1, 2, 1, 0, 0, 0, 0);
        cyc(7'h7f, 1, 2, 1, 0, 0, 1, 0);
        idle();
        idle();
        // async reset mid-MAC drops busy/stall before the next edge
        cyc(7'h7f, 1, 2, 1, 0, 0, 0, 0);
        cyc(7'h7f, 1, 2, 1, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("async_busy", 32'(mac_busy), 0);
        chk("async_stall", 32'(stall), 0);
        chk("async_abort", 32'(mac_abort), 0);
        chk("async_pc", 32'(pc_write_en), 1);
        model_reset();
        chk_counts();
        #1;
        reset = 1'b1;
        idle();
        // hold a hazard long enough to saturate the narrow counters, then clear
        repeat (20) cyc(7'h33, 3, 4, 1, 1, 3, 0, 0);
        repeat (20) cyc(7'h33, 3, 4, 1, 1, 9, 1, 0);
        cyc(7'h33, 3, 4, 1, 1, 3, 0, 1);
        idle();
        repeat (400) begin
            logic [6:0] op;
            op = $urandom_range(0, 19) == 0 ? 7'($urandom) : ops[$urandom_range(0, 9)];
            cyc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline controller that sequences the decode stage of the RISC-V core.
- Generates the decode-stage stall/flush controls plus PC and IF/ID write enables.
- Detects load-use hazards and branch/jump redirects, and schedules the multi-cycle MAC instruction (opcode 7'b1111111), holding the front end until it completes.
- Also keeps saturating stall/flush performance counters.

Parameters:
- MAC_CYCLES, 4: MAC execute latency in cycles; legal range 2..15.
- FLUSH_CYCLES, 2: number of cycles flush is held after a redirect; legal range 1..3.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_opcode  in  7  opcode of the instruction in IF/ID.
- id_rs1  in  5  Rs1 field of the instruction in IF/ID.
- id_rs2  in  5  Rs2 field of the instruction in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rd  in  5  destination register of the instruction in ID/EX.
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- stall  out  1  to decode: hold IF/ID and force a bubble into ID/EX.
- flush  out  1  to decode and IF/ID: squash younger instructions.
- pc_write_en  out  1  PC update enable.
- ifid_write_en  out  1  IF/ID register update enable.
- mac_start  out  1  one-cycle pulse that launches the MAC unit.
- mac_abort  out  1  one-cycle pulse that cancels an in-flight MAC.
- mac_busy  out  1  MAC in flight.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- State register and counters reset asynchronously when reset=0.
  - Reset values: state=RUN, counters 0, all outputs 0 except pc_write_en=1 and ifid_write_en=1.
- States: RUN, MAC_WAIT, REDIRECT. A 4-bit down-counter cnt is shared by MAC_WAIT and REDIRECT.
- Operand usage:
  - uses_rs1 is 0 for LUI, AUIPC and JAL; 1 otherwise.
  - uses_rs2 is 1 only for BCC, SCC, RCC and MAC.
- Load-use hazard (lu) is true when all hold:
  - id_valid and ex_mem_read, and ex_rd != 0;
  - (ex_rd==id_rs1 and uses_rs1) or (ex_rd==id_rs2 and uses_rs2).
- Outputs are Mealy, combinational from state and inputs. Priority each cycle: redirect > lu > MAC.
- RUN:
  - ex_redirect: flush=1 this cycle, flush_cnt+1. If FLUSH_CYCLES>1, go to REDIRECT with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - else lu: stall=1, pc_write_en=0, ifid_write_en=0 for exactly this cycle; stay in RUN. One bubble per load is required, because the next cycle ID/EX holds the bubble and lu clears.
  - else id_valid and id_opcode==MAC: mac_start=1, stall=1, pc_write_en=0, ifid_write_en=0; go to MAC_WAIT with cnt=MAC_CYCLES-2.
- MAC_WAIT:
  - mac_busy=1, stall=1, pc_write_en=0, ifid_write_en=0.
  - cnt==0: go to RUN. The MAC then leaves ID on the next cycle with stall=0.
  - Total stall for one MAC is exactly MAC_CYCLES cycles, counting the start cycle.
  - ex_redirect (defensive case): mac_abort=1, flush=1, stall=0, and go to REDIRECT per the RUN rule.
- REDIRECT:
  - flush=1, pc_write_en=1; new redirects are ignored.
  - cnt==0: go to RUN; otherwise cnt decrements.
- Invariants:
  - stall and flush are never both 1.
  - mac_start and mac_abort are never both 1.
  - mac_start is never asserted in the same cycle as flush.
- Counters:
  - stall_cnt increments on every cycle with stall=1; flush_cnt increments once per accepted redirect.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.
- Reset asserted mid-MAC: FSM returns to RUN immediately, mac_busy drops asynchronously, no mac_abort pulse is issued.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants: LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, MAC;
  - the state enumeration (RUN, MAC_WAIT, REDIRECT).
- One sub-module, sat_counter (parameter W; inc, clr, async active-low reset), instantiated twice for the performance counters.
- Hazard detection and FSM stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5; ID holds add x7,x5,x6 (RCC, rs1=5) -> stall=1, pc_write_en=0 for exactly 1 cycle, stall_cnt=1. Same case with ex_rd=0 -> no stall.
- rs2 filtering: ex_rd=6, ID holds addi x7,x6... (rs2 field happens to be 6, rs1=6) -> stall. ID holds lui with rs1/rs2 field bits equal to 6 -> no stall.
- MAC with MAC_CYCLES=4: MAC in ID, no hazard -> mac_start pulse in cycle 0; stall=1 in cycles 0-3; mac_busy=1 in cycles 1-3; stall=0 in cycle 4; stall_cnt=4.
- Redirect beats load-use: ex_redirect=1 and lu true together -> flush=1, stall=0. With FLUSH_CYCLES=2 -> flush=1 for 2 cycles, flush_cnt=1; a second ex_redirect in cycle 1 is not counted.
- Redirect in MAC_WAIT at cycle 2 -> mac_abort=1, flush=1, mac_busy=0 from cycle 3.
- Async reset mid-MAC: drop reset between clock edges -> mac_busy=0 and stall=0 immediately, before the next edge. cnt_clr with stall_cnt=0xFFFF -> 0 next cycle. Forced saturation -> stays 0xFFFF.
